// File: rtl/lm07_emu_pkg.sv
// Shared constants, state encoding, frame layout and temperature encoder for the LM07 emulator.
package lm07_emu_pkg;

  localparam int unsigned LM07_FRAME_BITS   = 16;
  localparam int unsigned LM07_CNT_W        = 5;
  localparam int unsigned LM07_MAX_MAG_DFLT = 99;
  localparam logic [1:0]  LM07_ID_BITS_DFLT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TAIL  = 2'd3
  } lm07_state_e;

  typedef struct packed {
    logic       sign;
    logic [6:0] mag;
    logic [5:0] rsvd;
    logic [1:0] id;
  } lm07_frame_t;

  typedef struct packed {
    lm07_frame_t word;
    logic        sat;
  } lm07_enc_t;

  // Sign/magnitude encode with clamp; magnitude is 8 bits wide so -128 maps to 128.
  function automatic lm07_enc_t lm07_encode(input logic [7:0] temp,
                                            input logic [7:0] max_mag,
                                            input logic [1:0] id);
    lm07_enc_t  r;
    logic [7:0] mag;
    mag   = temp[7] ? 8'(~temp + 8'd1) : temp;
    r.sat = (mag > max_mag);
    if (r.sat) mag = max_mag;
    r.word.sign = temp[7];
    r.word.mag  = 7'(mag);
    r.word.rsvd = '0;
    r.word.id   = id;
    return r;
  endfunction

endpackage

// File: rtl/lm07_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with registered rise/fall pulses.
module lm07_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic SYSCLK,
  input  logic RSTN,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Edge taken across the last two stages so the pulse lands SYNC_STAGES cycles after the pin.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    rise_d = ~sync_q[SYNC_STAGES-1] &  sync_q[SYNC_STAGES-2];
    fall_d =  sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-2];
  end

  // Chain resets low: a pin already low at reset release never yields a fall pulse.
  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      sync_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/lm07_emu.sv
// LM07 temperature-sensor SPI responder: shadow register, frame FSM and MSB-first shifter.
module lm07_emu
  import lm07_emu_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_MAG     = LM07_MAX_MAG_DFLT,
  parameter logic [1:0]  ID_BITS     = LM07_ID_BITS_DFLT
) (
  input  logic       SYSCLK,
  input  logic       RSTN,
  input  logic       CS,
  input  logic       SCK,
  output logic       SIO,
  output logic       SIO_OE,
  input  logic [7:0] temp_in,
  input  logic       temp_wr,
  output logic       busy,
  output logic       frame_done,
  output logic       short_frame,
  output logic       sat
);

  localparam lm07_frame_t SHADOW_RST = '{sign: 1'b0, mag: 7'd0, rsvd: 6'd0, id: ID_BITS};
  localparam logic [LM07_CNT_W-1:0] CNT_FULL = LM07_CNT_W'(LM07_FRAME_BITS);
  localparam logic [LM07_CNT_W-1:0] CNT_LAST = LM07_CNT_W'(LM07_FRAME_BITS - 1);

  logic cs_rise, cs_fall, sck_fall, sck_rise_unused;

  lm07_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .SYSCLK (SYSCLK),
    .RSTN   (RSTN),
    .din    (CS),
    .rise   (cs_rise),
    .fall   (cs_fall)
  );

  lm07_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .SYSCLK (SYSCLK),
    .RSTN   (RSTN),
    .din    (SCK),
    .rise   (sck_rise_unused),
    .fall   (sck_fall)
  );

  lm07_state_e                  state_q, state_d;
  lm07_frame_t                  shadow_q, shadow_d;
  logic [LM07_FRAME_BITS-1:0]   shift_q, shift_d;
  logic [LM07_CNT_W-1:0]        cnt_q, cnt_d;
  logic                         sio_q, sio_d;
  logic                         oe_q, oe_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         short_q, short_d;
  logic                         sat_q, sat_d;
  lm07_enc_t                    enc;

  // Shadow register and sat flag follow temp_wr regardless of frame activity.
  always_comb begin
    enc      = lm07_encode(temp_in, 8'(MAX_MAG), ID_BITS);
    shadow_d = shadow_q;
    sat_d    = sat_q;
    if (temp_wr) begin
      shadow_d = enc.word;
      sat_d    = enc.sat;
    end
  end

  // Frame FSM; a CS rise outranks any same-cycle SCK fall.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    sio_d   = sio_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    short_d = 1'b0;
    if ((state_q != ST_IDLE) && cs_rise) begin
      state_d = ST_IDLE;
      sio_d   = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = (cnt_q == CNT_FULL);
      short_d = (cnt_q != CNT_FULL);
    end else begin
      case (state_q)
        ST_IDLE: begin
          sio_d  = 1'b0;
          oe_d   = 1'b0;
          busy_d = 1'b0;
          if (cs_fall) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
        end
        ST_LOAD: begin
          shift_d = shadow_q;
          sio_d   = shadow_q.sign;
          oe_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sck_fall) begin
            shift_d = {shift_q[LM07_FRAME_BITS-2:0], 1'b0};
            sio_d   = shift_q[LM07_FRAME_BITS-2];
            cnt_d   = LM07_CNT_W'(cnt_q + 1'b1);
            if (cnt_q == CNT_LAST) begin
              state_d = ST_TAIL;
              sio_d   = 1'b0;
            end
          end
        end
        ST_TAIL: begin
          sio_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= ST_IDLE;
      shadow_q <= SHADOW_RST;
      shift_q  <= '0;
      cnt_q    <= '0;
      sio_q    <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      short_q  <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      sio_q    <= sio_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      short_q  <= short_d;
      sat_q    <= sat_d;
    end
  end

  assign SIO         = sio_q;
  assign SIO_OE      = oe_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign short_frame = short_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_lm07_emu.sv
// Directed bench for lm07_emu: acts as SPI master and host, checks captured frames and flags.
module tb_lm07_emu;

  localparam int unsigned SYNC_STAGES = 2;

  logic       SYSCLK;
  logic       RSTN;
  logic       CS;
  logic       SCK;
  logic       SIO;
  logic       SIO_OE;
  logic [7:0] temp_in;
  logic       temp_wr;
  logic       busy;
  logic       frame_done;
  logic       short_frame;
  logic       sat;

  int n_cmp;
  int n_err;
  int n_done;
  int n_short;

  lm07_emu #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .SYSCLK      (SYSCLK),
    .RSTN        (RSTN),
    .CS          (CS),
    .SCK         (SCK),
    .SIO         (SIO),
    .SIO_OE      (SIO_OE),
    .temp_in     (temp_in),
    .temp_wr     (temp_wr),
    .busy        (busy),
    .frame_done  (frame_done),
    .short_frame (short_frame),
    .sat         (sat)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  // Pulse counters sampled on the inactive edge.
  initial begin
    n_done  = 0;
    n_short = 0;
  end
  always @(negedge SYSCLK) begin
    if (frame_done)  n_done  = n_done + 1;
    if (short_frame) n_short = n_short + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge SYSCLK);
    #1;
  endtask

  task automatic host_wr(input logic [7:0] val);
    temp_in = val;
    temp_wr = 1'b1;
    wait_cyc(1);
    temp_wr = 1'b0;
    wait_cyc(1);
  endtask

  // Master frame: samples SIO at each SCK rise; optional host write after SCK number wr_after.
  task automatic run_frame(input int nsck, input int half, input int wr_after,
                           input logic [7:0] wr_val, output logic [31:0] cap);
    cap = '0;
    CS  = 1'b0;
    wait_cyc(half);
    for (int i = 0; i < nsck; i++) begin
      SCK = 1'b1;
      cap = {cap[30:0], SIO};
      wait_cyc(half);
      SCK = 1'b0;
      wait_cyc(half);
      if (i + 1 == wr_after) begin
        temp_in = wr_val;
        temp_wr = 1'b1;
        wait_cyc(1);
        temp_wr = 1'b0;
      end
    end
    CS = 1'b1;
    wait_cyc(half + 8);
  endtask

  logic [31:0] cap;
  int          d0;
  int          s0;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    RSTN    = 1'b0;
    CS      = 1'b1;
    SCK     = 1'b0;
    temp_in = 8'h00;
    temp_wr = 1'b0;
    wait_cyc(4);

    check("rst_sio",   32'(SIO),         32'd0);
    check("rst_oe",    32'(SIO_OE),      32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_done",  32'(frame_done),  32'd0);
    check("rst_short", 32'(short_frame), 32'd0);
    check("rst_sat",   32'(sat),         32'd0);
    RSTN = 1'b1;
    wait_cyc(6);

    // +25
    host_wr(8'd25);
    d0 = n_done; s0 = n_short;
    run_frame(16, 5, 0, 8'h00, cap);
    check("f25_word",  cap, 32'h0000_1903);
    check("f25_done",  32'(n_done - d0), 32'd1);
    check("f25_short", 32'(n_short - s0), 32'd0);
    check("f25_sat",   32'(sat), 32'd0);

    // -40, with CS-fall and CS-rise latency probes
    host_wr(8'hD8);
    s0 = n_short;
    CS = 1'b0;
    wait_cyc(SYNC_STAGES + 1);
    check("lat_oe_early", 32'(SIO_OE), 32'd0);
    wait_cyc(1);
    check("lat_oe_on",    32'(SIO_OE), 32'd1);
    check("lat_bit15",    32'(SIO),    32'd1);
    check("lat_busy",     32'(busy),   32'd1);
    wait_cyc(4);
    CS = 1'b1;
    wait_cyc(SYNC_STAGES);
    check("lat_short_early", 32'(short_frame), 32'd0);
    wait_cyc(1);
    check("lat_short_on",    32'(short_frame), 32'd1);
    wait_cyc(1);
    check("lat_short_pulse", 32'(short_frame), 32'd0);
    check("lat_short_cnt",   32'(n_short - s0), 32'd1);
    wait_cyc(6);
    run_frame(16, 5, 0, 8'h00, cap);
    check("fm40_word", cap, 32'h0000_A803);

    // +120 clamps
    host_wr(8'd120);
    check("f120_sat", 32'(sat), 32'd1);
    run_frame(16, 6, 0, 8'h00, cap);
    check("f120_word", cap, 32'h0000_6303);

    // -128 clamps
    host_wr(8'h80);
    check("fm128_sat", 32'(sat), 32'd1);
    run_frame(16, 5, 0, 8'h00, cap);
    check("fm128_word", cap, 32'h0000_E303);

    // write mid-frame only affects the next frame
    host_wr(8'd25);
    check("sat_clear", 32'(sat), 32'd0);
    run_frame(16, 5, 4, 8'd10, cap);
    check("mid_wr_cur",  cap, 32'h0000_1903);
    run_frame(16, 5, 0, 8'h00, cap);
    check("mid_wr_next", cap, 32'h0000_0A03);

    // short frame of 5 SCKs
    d0 = n_done; s0 = n_short;
    run_frame(5, 5, 0, 8'h00, cap);
    check("short_bits",  cap, 32'h0000_0001);
    check("short_pulse", 32'(n_short - s0), 32'd1);
    check("short_nodone", 32'(n_done - d0), 32'd0);
    check("short_oe",    32'(SIO_OE), 32'd0);
    check("short_busy",  32'(busy),   32'd0);
    run_frame(16, 5, 0, 8'h00, cap);
    check("after_short_word", cap, 32'h0000_0A03);

    // 20 SCKs: trailing bits read 0
    d0 = n_done; s0 = n_short;
    run_frame(20, 5, 0, 8'h00, cap);
    check("long_word",  cap, 32'h0000_A030);
    check("long_done",  32'(n_done - d0), 32'd1);
    check("long_short", 32'(n_short - s0), 32'd0);

    // ratio sweep 10..40 with -1
    host_wr(8'hFF);
    for (int r = 10; r <= 40; r += 10) begin
      d0 = n_done;
      run_frame(16, r / 2, 0, 8'h00, cap);
      check($sformatf("sweep%0d_word", r), cap, 32'h0000_8103);
      check($sformatf("sweep%0d_done", r), 32'(n_done - d0), 32'd1);
    end

    // reset mid-frame, CS held low through release
    host_wr(8'd25);
    d0 = n_done; s0 = n_short;
    CS = 1'b0;
    wait_cyc(6);
    for (int i = 0; i < 3; i++) begin
      SCK = 1'b1; wait_cyc(5);
      SCK = 1'b0; wait_cyc(5);
    end
    check("pre_rst_sio", 32'(SIO), 32'd1);
    check("pre_rst_oe",  32'(SIO_OE), 32'd1);
    RSTN = 1'b0;
    #1;
    check("mid_rst_sio",  32'(SIO),    32'd0);
    check("mid_rst_oe",   32'(SIO_OE), 32'd0);
    check("mid_rst_busy", 32'(busy),   32'd0);
    wait_cyc(3);
    RSTN = 1'b1;
    wait_cyc(6);
    for (int i = 0; i < 4; i++) begin
      SCK = 1'b1; wait_cyc(5);
      SCK = 1'b0; wait_cyc(5);
    end
    check("post_rst_busy", 32'(busy),   32'd0);
    check("post_rst_oe",   32'(SIO_OE), 32'd0);
    CS = 1'b1;
    wait_cyc(10);
    check("post_rst_nodone",  32'(n_done - d0),  32'd0);
    check("post_rst_noshort", 32'(n_short - s0), 32'd0);
    run_frame(16, 5, 0, 8'h00, cap);
    check("post_rst_word", cap, 32'h0000_0003);
    check("post_rst_done", 32'(n_done - d0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
